// File: rtl/random_range_gen.sv
// Fibonacci LFSR with seeding and a valid/ready port that returns a uniform
// value in [0, limit) using masked rejection sampling with a bounded retry count.
module random_range_gen #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
  parameter logic [WIDTH-1:0] SEED      = 8'h01,
  parameter int unsigned      OUT_W     = 5,
  parameter int unsigned      MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] req_limit,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_value,
  output logic             rsp_fallback,
  output logic [WIDTH-1:0] lfsr_state
);

  localparam int unsigned      TRY_W    = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    RESP   = 2'd2
  } state_e;

  // lim-1 smeared right gives all ones up to its MSB; lim=0 wraps to all ones.
  function automatic logic [OUT_W-1:0] range_mask(input logic [OUT_W-1:0] lim);
    logic [OUT_W-1:0] m;
    m = lim - {{(OUT_W-1){1'b0}}, 1'b1};
    for (int i = 1; i < OUT_W; i++) begin
      m = m | (m >> i);
    end
    return m;
  endfunction

  state_e           state_r, state_nxt_s;
  logic [WIDTH-1:0] lfsr_r, lfsr_nxt_s;
  logic [OUT_W-1:0] lim_r, lim_nxt_s;
  logic [TRY_W-1:0] tries_r, tries_nxt_s;
  logic [OUT_W-1:0] value_r, value_nxt_s;
  logic             fallback_r, fallback_nxt_s;
  logic [OUT_W-1:0] cand_s;
  logic             accept_s;

  assign cand_s   = lfsr_r[OUT_W-1:0] & range_mask(lim_r);
  assign accept_s = (lim_r == {OUT_W{1'b0}}) || (cand_s < lim_r);

  // LFSR next state: seed load wins over a (single) advance
  always_comb begin
    lfsr_nxt_s = lfsr_r;
    if (seed_load) begin
      lfsr_nxt_s = (seed_in == {WIDTH{1'b0}}) ? SEED : seed_in;
    end else if (step || (state_r == SAMPLE)) begin
      lfsr_nxt_s = {lfsr_r[WIDTH-2:0], ^(lfsr_r & TAPS)};
    end else begin
      lfsr_nxt_s = lfsr_r;
    end
  end

  // Request FSM next state and response data
  always_comb begin
    state_nxt_s    = state_r;
    lim_nxt_s      = lim_r;
    tries_nxt_s    = tries_r;
    value_nxt_s    = value_r;
    fallback_nxt_s = fallback_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          lim_nxt_s   = req_limit;
          tries_nxt_s = {TRY_W{1'b0}};
          state_nxt_s = SAMPLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SAMPLE: begin
        if (accept_s) begin
          value_nxt_s    = cand_s;
          fallback_nxt_s = 1'b0;
          state_nxt_s    = RESP;
        end else if (tries_r == LAST_TRY) begin
          value_nxt_s    = {OUT_W{1'b0}};
          fallback_nxt_s = 1'b1;
          state_nxt_s    = RESP;
        end else begin
          tries_nxt_s = tries_r + {{(TRY_W-1){1'b0}}, 1'b1};
          state_nxt_s = SAMPLE;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any request in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      lfsr_r     <= SEED;
      lim_r      <= {OUT_W{1'b0}};
      tries_r    <= {TRY_W{1'b0}};
      value_r    <= {OUT_W{1'b0}};
      fallback_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      lfsr_r     <= lfsr_nxt_s;
      lim_r      <= lim_nxt_s;
      tries_r    <= tries_nxt_s;
      value_r    <= value_nxt_s;
      fallback_r <= fallback_nxt_s;
    end
  end

  assign req_ready    = (state_r == IDLE);
  assign rsp_valid    = (state_r == RESP);
  assign rsp_value    = value_r;
  assign rsp_fallback = fallback_r;
  assign lfsr_state   = lfsr_r;

endmodule

// File: tb/tb_random_range_gen.sv
// Self-checking bench for random_range_gen: directed scenarios plus a random soak
// against a cycle model that feeds a response scoreboard.
module tb_random_range_gen;

  localparam int MT = 8;

  logic       clk = 1'b0;
  logic       rst, step, seed_load, req_valid, rsp_ready;
  logic [7:0] seed_in;
  logic [4:0] req_limit;
  logic       req_ready, rsp_valid, rsp_fallback;
  logic [4:0] rsp_value;
  logic [7:0] lfsr_state;
  logic       req_ready_2, rsp_valid_2, rsp_fallback_2;
  logic [4:0] rsp_value_2;
  logic [7:0] lfsr_state_2;

  always #5 clk = ~clk;

  random_range_gen dut (
    .clk(clk), .rst(rst), .step(step), .seed_load(seed_load), .seed_in(seed_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_limit(req_limit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_value(rsp_value),
    .rsp_fallback(rsp_fallback), .lfsr_state(lfsr_state)
  );

  random_range_gen #(.MAX_TRIES(2)) dut2 (
    .clk(clk), .rst(rst), .step(step), .seed_load(seed_load), .seed_in(seed_in),
    .req_valid(req_valid), .req_ready(req_ready_2), .req_limit(req_limit),
    .rsp_valid(rsp_valid_2), .rsp_ready(rsp_ready), .rsp_value(rsp_value_2),
    .rsp_fallback(rsp_fallback_2), .lfsr_state(lfsr_state_2)
  );

  typedef struct {
    logic [4:0] value;
    logic       fallback;
    logic [4:0] lim;
  } rsp_t;

  rsp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_lfsr;
  int         m_state;
  logic [4:0] m_lim;
  int         m_tries;

  function automatic logic [7:0] ref_next(input logic [7:0] s);
    logic [7:0] taps;
    logic       fb;
    taps = 8'hB8;
    fb   = 1'b0;
    for (int i = 0; i < 8; i++) if (taps[i]) fb = fb ^ s[i];
    return {s[6:0], fb};
  endfunction

  function automatic logic [4:0] ref_mask(input logic [4:0] lim);
    int p;
    if (lim == 5'd0) return 5'h1F;
    p = 1;
    while (p < int'(lim)) p = p * 2;
    return 5'(p - 1);
  endfunction

  task automatic model_reset();
    m_lfsr  = 8'h01;
    m_state = 0;
    m_lim   = 5'd0;
    m_tries = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, advance the model, and land #1 after the edge
  task automatic cyc(input logic st, input logic sl, input logic [7:0] si,
                     input logic rv, input logic [4:0] rl, input logic rr);
    logic       adv;
    logic [4:0] cand;
    rsp_t       e;
    step = st; seed_load = sl; seed_in = si; req_valid = rv; req_limit = rl; rsp_ready = rr;
    adv = st || (m_state == 1);
    case (m_state)
      0: if (rv) begin m_lim = rl; m_tries = 0; m_state = 1; end
      1: begin
        cand = m_lfsr[4:0] & ref_mask(m_lim);
        if (m_lim == 5'd0 || cand < m_lim) begin
          e.value = cand; e.fallback = 1'b0; e.lim = m_lim; exp_q.push_back(e); m_state = 2;
        end else if (m_tries == MT - 1) begin
          e.value = 5'd0; e.fallback = 1'b1; e.lim = m_lim; exp_q.push_back(e); m_state = 2;
        end else begin
          m_tries++;
        end
      end
      default: if (rr) m_state = 0;
    endcase
    if (sl) m_lfsr = (si == 8'h00) ? 8'h01 : si;
    else if (adv) m_lfsr = ref_next(m_lfsr);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step = 1'b0; seed_load = 1'b0; seed_in = 8'h00;
    req_valid = 1'b0; req_limit = 5'd0; rsp_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step = 1'b0; seed_load = 1'b0; seed_in = 8'h00;
    req_valid = 1'b0; req_limit = 5'd0; rsp_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++; if (lfsr_state !== 8'h01) begin errors++; $display("FAIL reset_lfsr: got %h expected 01", lfsr_state); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_value !== 5'd0) begin errors++; $display("FAIL reset_rsp_value: got %h expected 00", rsp_value); end
    checks++; if (rsp_fallback !== 1'b0) begin errors++; $display("FAIL reset_fallback: got %b expected 0", rsp_fallback); end
    rst = 1'b0;
  endtask

  task automatic test_sequence();
    logic [7:0] exp_seq[7] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    int         n;
    logic       zero_seen;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
      checks++;
      if (lfsr_state !== exp_seq[i]) begin errors++; $display("FAIL seq_%0d: got %h expected %h", i, lfsr_state, exp_seq[i]); end
    end
    n = 7;
    zero_seen = 1'b0;
    while (lfsr_state !== 8'h01 && n < 300) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
      n++;
      if (lfsr_state === 8'h00) zero_seen = 1'b1;
    end
    checks++; if (n != 255) begin errors++; $display("FAIL period: got %0d expected 255", n); end
    checks++; if (zero_seen) begin errors++; $display("FAIL zero_state: got 1 expected 0"); end
  endtask

  task automatic test_seed();
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 1'b0);
    checks++; if (lfsr_state !== 8'h01) begin errors++; $display("FAIL seed_zero: got %h expected 01", lfsr_state); end
    cyc(1'b1, 1'b1, 8'h5A, 1'b0, 5'd0, 1'b0);
    checks++; if (lfsr_state !== 8'h5A) begin errors++; $display("FAIL seed_5a: got %h expected 5a", lfsr_state); end
  endtask

  task automatic test_basic_request();
    rsp_t e;
    do_reset();
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 5'd5, 1'b0);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", req_ready); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_value !== 5'd1) begin errors++; $display("FAIL basic_value: got %h expected 01", rsp_value); end
    checks++; if (rsp_fallback !== 1'b0) begin errors++; $display("FAIL basic_fallback: got %b expected 0", rsp_fallback); end
    checks++; if (lfsr_state !== 8'h02) begin errors++; $display("FAIL basic_lfsr: got %h expected 02", lfsr_state); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL basic_sb: got empty queue expected entry"); end
    else begin
      e = exp_q.pop_front();
      if (rsp_value !== e.value) begin errors++; $display("FAIL basic_sb: got %h expected %h", rsp_value, e.value); end
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_handshake: got ready=%b valid=%b expected 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_rejection();
    rsp_t e;
    do_reset();
    cyc(1'b0, 1'b1, 8'h07, 1'b0, 5'd0, 1'b0);
    checks++; if (lfsr_state !== 8'h07) begin errors++; $display("FAIL rej_seed: got %h expected 07", lfsr_state); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 5'd5, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
      if (i < 4) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rej_early_%0d: got %b expected 0", i, rsp_valid); end
      end
      if (i == 2) begin
        checks++;
        if (rsp_valid_2 !== 1'b1 || rsp_value_2 !== 5'd0 || rsp_fallback_2 !== 1'b1) begin
          errors++; $display("FAIL rej_fallback: got v=%b val=%h fb=%b expected 1/00/1", rsp_valid_2, rsp_value_2, rsp_fallback_2);
        end
      end
    end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rej_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_value !== 5'd2 || rsp_fallback !== 1'b0) begin errors++; $display("FAIL rej_value: got %h/%b expected 02/0", rsp_value, rsp_fallback); end
    checks++; if (lfsr_state !== 8'h75) begin errors++; $display("FAIL rej_lfsr: got %h expected 75", lfsr_state); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL rej_sb: got empty queue expected entry"); end
    else begin
      e = exp_q.pop_front();
      if (rsp_value !== e.value) begin errors++; $display("FAIL rej_sb: got %h expected %h", rsp_value, e.value); end
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
  endtask

  task automatic test_limits();
    rsp_t e;
    do_reset();
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
    checks++; if (rsp_valid !== 1'b1 || rsp_value !== 5'd0 || rsp_fallback !== 1'b0) begin errors++; $display("FAIL lim1: got v=%b val=%h fb=%b expected 1/00/0", rsp_valid, rsp_value, rsp_fallback); end
    if (exp_q.size() != 0) e = exp_q.pop_front();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
    checks++; if (lfsr_state !== 8'h8E) begin errors++; $display("FAIL lim0_pre: got %h expected 8e", lfsr_state); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
    checks++; if (rsp_valid !== 1'b1 || rsp_value !== 5'h0E) begin errors++; $display("FAIL lim0: got v=%b val=%h expected 1/0e", rsp_valid, rsp_value); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL lim0_sb: got empty queue expected entry"); end
    else begin
      e = exp_q.pop_front();
      if (rsp_value !== e.value) begin errors++; $display("FAIL lim0_sb: got %h expected %h", rsp_value, e.value); end
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 5'd3, 1'b0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_value !== 5'h0E || req_ready !== 1'b0) begin
        errors++; $display("FAIL hold_%0d: got v=%b val=%h rdy=%b expected 1/0e/0", i, rsp_valid, rsp_value, req_ready);
      end
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
  endtask

  task automatic test_rst_mid();
    do_reset();
    cyc(1'b0, 1'b1, 8'h07, 1'b0, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 5'd5, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", rsp_valid); end
    checks++; if (lfsr_state !== 8'h01) begin errors++; $display("FAIL rstmid_lfsr: got %h expected 01", lfsr_state); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_noresp_%0d: got %b expected 0", i, rsp_valid); end
    end
  endtask

  task automatic test_soak();
    logic       st, sl, rv, rr;
    logic [7:0] si;
    logic [4:0] rl;
    rsp_t       e;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      st = 1'($urandom_range(1, 0));
      sl = ($urandom_range(31, 0) == 0);
      si = 8'($urandom);
      rv = 1'($urandom_range(1, 0));
      rl = 5'($urandom);
      rr = ($urandom_range(2, 0) != 0);
      if (rsp_valid === 1'b1 && rr) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL soak_sb_%0d: got response expected none", i); end
        else begin
          e = exp_q.pop_front();
          if (rsp_value !== e.value || rsp_fallback !== e.fallback || (e.lim != 5'd0 && rsp_value >= e.lim)) begin
            errors++; $display("FAIL soak_rsp_%0d: got %h/%b expected %h/%b lim %0d", i, rsp_value, rsp_fallback, e.value, e.fallback, e.lim);
          end
        end
      end
      cyc(st, sl, si, rv, rl, rr);
      checks++;
      if (lfsr_state !== m_lfsr || req_ready !== (m_state == 0) || rsp_valid !== (m_state == 2)) begin
        errors++; $display("FAIL soak_state_%0d: got lfsr=%h rdy=%b v=%b expected %h/%b/%b", i, lfsr_state, req_ready, rsp_valid, m_lfsr, (m_state == 0), (m_state == 2));
      end
    end
  endtask

  initial begin
    rst = 1'b1; step = 1'b0; seed_load = 1'b0; seed_in = 8'h00;
    req_valid = 1'b0; req_limit = 5'd0; rsp_ready = 1'b0;
    test_reset();
    test_sequence();
    test_seed();
    test_basic_request();
    test_rejection();
    test_limits();
    test_rst_mid();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
